// File: rtl/seq_mult_16bit_cla.sv
// rtl/seq_mult_16bit_cla.sv - sequential unsigned 16x16->32 shift-and-add multiplier
//
// Purpose: multi-cycle MUL path. One CLA_16bit_ripple adder (cin=0) forms
//          ACC+M every cycle; a RUN step either takes that sum or plain ACC,
//          then shifts {carry, ACC, Q} right by one. 16 steps, then DONE.
// Ports:
//   clk     - clock, rising edge
//   rst     - synchronous active-high reset
//   start   - request, only honoured in IDLE
//   a, b    - unsigned multiplicand / multiplier, captured on accepted start
//   busy    - high in RUN and DONE
//   done    - one-cycle pulse in DONE
//   product - last completed result, held until the next completion

// 4-bit carry-lookahead slice.
// Ports: a, b, cin -> sum, cout
module cla_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [3:0] p;
  logic [3:0] g;
  logic [4:0] c;

  assign p = a ^ b;
  assign g = a & b;

  // Fully expanded lookahead carries within the slice.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  assign sum  = p ^ c[3:0];
  assign cout = c[4];
endmodule

// 16-bit adder: four CLA slices with the carry rippling between slices.
// Ports: a, b, cin -> sum, cout
module CLA_16bit_ripple (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);
  logic [4:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < 4; i++) begin : g_slice
    cla_4bit u_slice (
      .a    (a[4*i +: 4]),
      .b    (b[4*i +: 4]),
      .cin  (c[i]),
      .sum  (sum[4*i +: 4]),
      .cout (c[i+1])
    );
  end

  assign cout = c[4];
endmodule

module seq_mult_16bit_cla (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] product
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] m_q, m_d;
  logic [15:0] acc_q, acc_d;
  logic [15:0] q_q, q_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] product_q, product_d;

  logic [15:0] add_sum;
  logic        add_cout;

  // Datapath values after one shift-and-add step.
  logic [15:0] acc_step;
  logic [15:0] q_step;

  CLA_16bit_ripple u_adder (
    .a    (acc_q),
    .b    (m_q),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      m_q       <= '0;
      acc_q     <= '0;
      q_q       <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      acc_q     <= acc_d;
      q_q       <= q_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    acc_d     = acc_q;
    q_d       = q_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    busy      = 1'b0;
    done      = 1'b0;

    // The adder carry becomes the new ACC MSB, so the 17-bit sum is never
    // truncated; when Q[0]=0 the shift brings in a zero instead.
    if (q_q[0]) begin
      acc_step = {add_cout, add_sum[15:1]};
      q_step   = {add_sum[0], q_q[15:1]};
    end else begin
      acc_step = {1'b0, acc_q[15:1]};
      q_step   = {acc_q[0], q_q[15:1]};
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          m_d     = a;
          q_d     = b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        busy  = 1'b1;
        acc_d = acc_step;
        q_d   = q_step;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd15) begin
          product_d = {acc_step, q_step};
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign product = product_q;
endmodule

// File: tb/tb_seq_mult_16bit_cla.sv
// tb/tb_seq_mult_16bit_cla.sv - self-checking bench for seq_mult_16bit_cla
module tb_seq_mult_16bit_cla;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        busy;
  logic        done;
  logic [31:0] product;

  int checks = 0;
  int errors = 0;

  // Reference: cycles elapsed since the accepted start (0 = idle).
  int          mdl_cyc = 0;
  logic [15:0] mdl_a = '0;
  logic [15:0] mdl_b = '0;
  logic [31:0] mdl_prod = '0;
  bit          mdl_valid = 1'b0;

  seq_mult_16bit_cla dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      mdl_cyc   = 0;
      mdl_prod  = '0;
      mdl_valid = 1'b1;
    end else if (mdl_cyc == 0) begin
      if (start) begin
        mdl_cyc = 1;
        mdl_a   = a;
        mdl_b   = b;
      end
    end else if (mdl_cyc == 17) begin
      mdl_cyc = 0;
    end else begin
      mdl_cyc++;
      if (mdl_cyc == 17) mdl_prod = 32'(mdl_a) * 32'(mdl_b);
    end
  end

  always @(negedge clk) begin
    if (mdl_valid) begin
      check("model busy", {31'd0, busy}, {31'd0, mdl_cyc != 0});
      check("model done", {31'd0, done}, {31'd0, mdl_cyc == 17});
      check("model product", product, mdl_prod);
    end
  end

  // Start one operation, wait for done, pin latency and result literally.
  task automatic do_mult(input logic [15:0] x, input logic [15:0] y,
                         input logic [31:0] expv, input string nm);
    int n;
    @(negedge clk);
    a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({nm, " latency"}, 32'(n), 32'd17);
    check({nm, " product"}, product, expv);
  endtask

  initial begin
    int n;
    int pulses;
    logic [15:0] rx, ry;

    repeat (2) @(negedge clk);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset product", product, 32'd0);
    rst = 1'b0;

    do_mult(16'd5, 16'd9, 32'd45, "5x9");
    do_mult(16'hFFFF, 16'hFFFF, 32'hFFFE0001, "ffffxffff");
    do_mult(16'h8000, 16'h0002, 32'h00010000, "8000x2");
    do_mult(16'd0, 16'h1234, 32'd0, "0x1234");
    do_mult(16'd111, 16'd1, 32'd111, "111x1");
    do_mult(16'd41, 16'd0, 32'd0, "41x0");

    // Ignored starts in cycles 5 and 17.
    @(negedge clk);
    a = 16'd15; b = 16'd9; start = 1'b1;
    pulses = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (done) pulses++;
      if (c == 17) check("ignored product", product, 32'd135);
      if (c == 5 || c == 17) begin
        a = 16'd2; b = 16'd3; start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    check("ignored done pulses", 32'(pulses), 32'd1);
    check("ignored final product", product, 32'd135);

    // Reset mid-operation in cycle 8.
    @(negedge clk);
    a = 16'd111; b = 16'd41; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (n < 8) begin
      @(negedge clk);
      n++;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort done", {31'd0, done}, 32'd0);
    check("abort product", product, 32'd0);
    pulses = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("abort no done", 32'(pulses), 32'd0);
    do_mult(16'd2, 16'd3, 32'd6, "2x3 after abort");

    // Simultaneous reset and start: start dropped.
    @(negedge clk);
    a = 16'd7; b = 16'd7; start = 1'b1; rst = 1'b1;
    @(negedge clk);
    start = 1'b0; rst = 1'b0;
    check("rst+start busy", {31'd0, busy}, 32'd0);
    check("rst+start product", product, 32'd0);

    // Back-to-back with hold of the first result.
    do_mult(16'd5, 16'd9, 32'd45, "b2b first");
    @(negedge clk);
    a = 16'd1000; b = 16'd1000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (!done && n < 40) begin
      if (n == 16) check("b2b hold", product, 32'd45);
      @(negedge clk);
      n++;
    end
    check("b2b latency", 32'(n), 32'd17);
    check("b2b second", product, 32'd1000000);

    for (int i = 0; i < 20; i++) begin
      rx = 16'($urandom);
      ry = 16'($urandom);
      do_mult(rx, ry, 32'(rx) * 32'(ry), "random");
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
